// File: rtl/alu_shift_pkg.sv
// Op encodings and FSM states shared by the iterative shifter and its step unit.
package alu_shift_pkg;

    typedef enum logic [1:0] {
        OP_SRA = 2'b00,
        OP_SRL = 2'b01,
        OP_SLL = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Bits needed to hold a shift amount of 0..width inclusive (width a power of two).
    function automatic int amt_bits(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single combinational shift of 0..STEP positions for one op.
// Zero latency; no flow control, the caller decides when to register the result.
module shift_step
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = amt_bits(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  op_t              op,
    input  logic [CW-1:0]    k,
    output logic [WIDTH-1:0] result
);

    localparam logic [CW-1:0] W_C = CW'(WIDTH);

    logic [WIDTH-1:0] srl_val;
    logic [WIDTH-1:0] fill_mask;

    always_comb begin
        srl_val   = data >> k;
        fill_mask = ~({WIDTH{1'b1}} >> k);
        result    = srl_val;
        case (op)
            // MSB of the working value is always the captured sign during SRA
            OP_SRA: result = data[WIDTH-1] ? (srl_val | fill_mask) : srl_val;
            OP_SRL: result = srl_val;
            OP_SLL: result = data << k;
            OP_ROR: result = srl_val | (data << (W_C - k));
            default: result = srl_val;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Iterative shifter: up to STEP positions per cycle, result after 1 + ceil(n/STEP) edges.
// One request in flight; in_ready only in IDLE, result held in DONE until out_ready.
module iter_shifter
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             zero
);

    localparam int            LW     = $clog2(WIDTH);
    localparam int            CW     = amt_bits(WIDTH);
    localparam logic [CW-1:0] STEP_C = CW'(STEP);
    localparam logic [CW-1:0] FULL_C = {1'b1, {LW{1'b0}}};

    state_t           state;
    state_t           state_nxt;
    op_t              op_q;
    logic [WIDTH-1:0] work;
    logic [CW-1:0]    n_rem;
    logic [CW-1:0]    n_eff;
    logic [CW-1:0]    k;
    logic [WIDTH-1:0] step_out;
    logic             b_over;
    logic             accept;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_ready && in_valid && !flush;

    // Any set bit above the low LW bits means b >= WIDTH.
    assign b_over = |b[WIDTH-1:LW];

    always_comb begin
        n_eff = {1'b0, b[LW-1:0]};
        if (op_t'(op) != OP_ROR && b_over) begin
            n_eff = FULL_C;
        end
    end

    assign k = (n_rem > STEP_C) ? STEP_C : n_rem;

    shift_step #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_shift_step (
        .data   (work),
        .op     (op_q),
        .k      (k),
        .result (step_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_valid) state_nxt = ST_SHIFT;
            ST_SHIFT: if (n_rem == '0) state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work  <= '0;
            op_q  <= OP_SRA;
            n_rem <= '0;
            r     <= '0;
            zero  <= 1'b0;
        end else if (flush) begin
            n_rem <= '0;
            r     <= '0;
            zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        work  <= a;
                        op_q  <= op_t'(op);
                        n_rem <= n_eff;
                    end
                end
                ST_SHIFT: begin
                    if (n_rem != '0) begin
                        work  <= step_out;
                        n_rem <= n_rem - k;
                    end else begin
                        r    <= work;
                        zero <= (work == '0);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r    <= '0;
                        zero <= 1'b0;
                    end
                end
                default: begin
                    n_rem <= '0;
                    r     <= '0;
                    zero  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter: one STEP=1 and one STEP=3 instance, WIDTH=8.
module tb_iter_shifter;

    typedef struct {
        logic [7:0] r;
        logic       zero;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [1:0] op = '0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;
    logic       sel = 1'b0;

    logic       in_ready1, out_valid1, zero1, in_ready3, out_valid3, zero3;
    logic [7:0] r1, r3;
    logic       in_valid1, in_valid3;
    logic       obs_in_ready, obs_out_valid, obs_zero;
    logic [7:0] obs_r;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    assign in_valid1 = in_valid & ~sel;
    assign in_valid3 = in_valid & sel;
    assign obs_in_ready  = sel ? in_ready3  : in_ready1;
    assign obs_out_valid = sel ? out_valid3 : out_valid1;
    assign obs_zero      = sel ? zero3      : zero1;
    assign obs_r         = sel ? r3         : r1;

    iter_shifter #(.WIDTH(8), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .op(op), .flush(flush), .out_valid(out_valid1),
        .out_ready(out_ready), .r(r1), .zero(zero1)
    );

    iter_shifter #(.WIDTH(8), .STEP(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .a(a), .b(b), .op(op), .flush(flush), .out_valid(out_valid3),
        .out_ready(out_ready), .r(r3), .zero(zero3)
    );

    function automatic exp_t model(input logic [1:0] fop, input logic [7:0] fa,
                                   input logic [7:0] fb, input int step);
        exp_t e;
        logic signed [7:0] sa;
        int m;
        int n;
        sa = fa;
        m  = int'(fb) % 8;
        n  = (fop == 2'b11) ? m : ((fb > 8) ? 8 : int'(fb));
        case (fop)
            2'b00: e.r = (fb >= 8) ? {8{fa[7]}} : 8'(sa >>> fb);
            2'b01: e.r = fa >> fb;
            2'b10: e.r = fa << fb;
            default: e.r = (fa >> m) | (fa << (8 - m));
        endcase
        e.zero = (e.r == 8'h00);
        e.lat  = 1 + (n + step - 1) / step;
        return e;
    endfunction

    // Drives one request, waits for the result, stalls for hold cycles, then drains it.
    task automatic do_req(input logic [1:0] top, input logic [7:0] ta, input logic [7:0] tb,
                          input int hold, input string name);
        exp_t e;
        int   cnt;
        logic [7:0] r_seen;
        logic       z_seen;
        op = top; a = ta; b = tb; in_valid = 1'b1;
        sb.push_back(model(top, ta, tb, sel ? 3 : 1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        cnt = 0;
        while (!obs_out_valid && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        e = sb.pop_front();
        n_cmp++;
        if (!obs_out_valid) begin
            n_bad++;
            $display("FAIL %s timeout: out_valid=%b required 1", name, obs_out_valid);
            return;
        end
        n_cmp += 3;
        if (cnt !== e.lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d required %0d", name, cnt, e.lat);
        end
        if (obs_r !== e.r) begin
            n_bad++;
            $display("FAIL %s r: got %h required %h", name, obs_r, e.r);
        end
        if (obs_zero !== e.zero) begin
            n_bad++;
            $display("FAIL %s zero: got %b required %b", name, obs_zero, e.zero);
        end
        r_seen = obs_r;
        z_seen = obs_zero;
        for (int i = 0; i < hold; i++) begin
            in_valid = (i % 2 == 0);
            op = 2'b10; a = 8'h01; b = 8'h01;
            @(posedge clk); #1;
            n_cmp++;
            if (obs_out_valid !== 1'b1 || obs_in_ready !== 1'b0 || obs_r !== r_seen || obs_zero !== z_seen) begin
                n_bad++;
                $display("FAIL %s stall%0d: valid=%b ready=%b r=%h zero=%b required 1 0 %h %b",
                         name, i, obs_out_valid, obs_in_ready, obs_r, obs_zero, r_seen, z_seen);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1 || obs_r !== 8'h00 || obs_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL %s drain: valid=%b ready=%b r=%h zero=%b required 0 1 00 0",
                     name, obs_out_valid, obs_in_ready, obs_r, obs_zero);
        end
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1 || obs_r !== 8'h00 || obs_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle: valid=%b ready=%b r=%h zero=%b required 0 1 00 0",
                     name, obs_out_valid, obs_in_ready, obs_r, obs_zero);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_idle("reset_s1");
        sel = 1'b1;
        check_idle("reset_s3");
        sel = 1'b0;
    endtask

    task automatic test_ops();
        do_req(2'b00, 8'h96, 8'd3,   0, "sra_96_3");
        do_req(2'b01, 8'h96, 8'd3,   0, "srl_96_3");
        do_req(2'b10, 8'h96, 8'd9,   0, "sll_96_9");
        do_req(2'b00, 8'h80, 8'd200, 0, "sra_80_200");
        do_req(2'b11, 8'h96, 8'd12,  0, "ror_96_12");
        do_req(2'b01, 8'hF0, 8'd8,   0, "srl_f0_8");
        for (int o = 0; o < 4; o++) begin
            do_req(2'(o), 8'hA5, 8'd0, 0, "b_zero");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            do_req(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 20)), 0, "rand");
        end
    endtask

    task automatic test_stall();
        do_req(2'b00, 8'h96, 8'd3, 3, "stall_sra");
        repeat (2) @(posedge clk);
        #1;
        check_idle("stall_no_accept");
    endtask

    // Abandon a request mid-shift by flush or by reset, then run a clean one.
    task automatic test_abort(input logic use_rst, input string name);
        op = 2'b11; a = 8'h96; b = 8'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        if (use_rst) rst_n = 1'b0;
        flush = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        check_idle(name);
        repeat (8) @(posedge clk);
        #1;
        check_idle(name);
        do_req(2'b00, 8'h96, 8'd3, 0, name);
    endtask

    task automatic test_step3();
        sel = 1'b1;
        do_req(2'b00, 8'h96, 8'd7,  0, "s3_sra_96_7");
        do_req(2'b10, 8'h96, 8'd8,  0, "s3_sll_96_8");
        do_req(2'b11, 8'h96, 8'd5,  0, "s3_ror_96_5");
        do_req(2'b01, 8'hFF, 8'd2,  0, "s3_srl_ff_2");
        do_req(2'b00, 8'h40, 8'd0,  0, "s3_sra_b0");
        do_req(2'b00, 8'h96, 8'd3,  2, "s3_stall");
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ops();
        test_random();
        test_stall();
        test_abort(1'b0, "flush_mid");
        test_abort(1'b1, "reset_mid");
        test_step3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
